detector_scan_ctrl: RTL and testbench

//  Word-level sequencer for the serial 1011 pattern detector path.
//  - Accepts a parallel word over a valid/ready handshake.
//  - Shifts the word out MSB-first, one bit per clock, through an internal PAT_W-bit pattern matcher.
//  - Flags each match, counts matches, and pulses done when the word is finished.
//  - Sits between a word-oriented producer and the serial detection datapath.

---
 rtl/detector_scan_if.sv | 38 +++
 rtl/detector_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_detector_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/detector_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : detector_scan_if
// Purpose  : Bundles the word handshake and the serial/status outputs of the
//            detector scan controller.
// Signals  : in_valid/in_ready/in_data/overlap/abort  producer -> controller
//            ser_valid/ser_bit/match                  serial bit stream
//            busy/done/match_cnt                      status
// Modports : master (producer / bench side), slave (controller side)
// Revision : 1.0  initial release
// ============================================================================
interface detector_scan_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              overlap;
  logic              abort;
  logic              ser_valid;
  logic              ser_bit;
  logic              match;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  match_cnt;

  modport master (
    output in_valid, in_data, overlap, abort,
    input  in_ready, ser_valid, ser_bit, match, busy, done, match_cnt
  );

  modport slave (
    input  in_valid, in_data, overlap, abort,
    output in_ready, ser_valid, ser_bit, match, busy, done, match_cnt
  );
endinterface
`default_nettype wire

// File: rtl/detector_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : detector_scan_ctrl
// Purpose  : Accepts a parallel word, shifts it out MSB-first one bit per
//            clock through a PAT_W-bit pattern matcher, flags and counts
//            matches, and pulses done when the word is finished.
// Ports    : clk    rising-edge clock
//            clr_n  synchronous active-low reset
//            bus    detector_scan_if.slave (handshake, serial and status)
// Revision : 1.0  initial release
// ============================================================================
module detector_scan_ctrl #(
  parameter int                 DATA_W = 16,
  parameter int                 PAT_W  = 4,
  parameter logic [PAT_W-1:0]   PAT    = 4'b1011,
  parameter int                 CNT_W  = 5
) (
  input  wire logic        clk,
  input  wire logic        clr_n,
  detector_scan_if.slave   bus
);

  localparam int                  c_FILL_W    = $clog2(PAT_W + 1);
  localparam int                  c_IDX_W     = $clog2(DATA_W + 1);
  localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(PAT_W);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DATA_W);
  localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_word;
  logic [c_IDX_W-1:0]  r_idx;
  logic [PAT_W-1:0]    r_hist;
  logic [c_FILL_W-1:0] r_fill;
  logic                r_ovl;
  logic                r_ser_valid;
  logic                r_ser_bit;
  logic                r_match;
  logic                r_done;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_accept;
  logic                w_bit;
  logic                w_ovl;
  logic [PAT_W-1:0]    w_hist_base;
  logic [PAT_W-1:0]    w_hist_next;
  logic [c_FILL_W-1:0] w_fill_base;
  logic [c_FILL_W-1:0] w_fill_next;
  logic [CNT_W-1:0]    w_cnt_base;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_hit;

  // Matcher evaluation for the bit being emitted on this edge. On the accept
  // edge the first bit comes straight from in_data and the history, fill count
  // and match count start from zero so matches never span two words.
  always_comb begin
    w_accept    = (r_state == IDLE) && bus.in_valid;
    w_bit       = w_accept ? bus.in_data[DATA_W-1] : r_word[DATA_W-1];
    w_ovl       = w_accept ? bus.overlap : r_ovl;
    w_hist_base = w_accept ? '0 : r_hist;
    w_fill_base = w_accept ? '0 : r_fill;
    w_cnt_base  = w_accept ? '0 : r_cnt;
    w_hist_next = (w_hist_base << 1) | PAT_W'(w_bit);
    w_fill_next = (w_fill_base == c_FILL_FULL) ? w_fill_base : w_fill_base + 1'b1;
    w_hit       = (w_fill_next == c_FILL_FULL) && (w_hist_next == PAT);
    w_cnt_next  = (w_hit && (w_cnt_base != c_CNT_MAX)) ? w_cnt_base + 1'b1 : w_cnt_base;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_idx       <= '0;
      r_hist      <= '0;
      r_fill      <= '0;
      r_ovl       <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_bit   <= 1'b0;
      r_match     <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ser_valid <= 1'b0;
          r_match     <= 1'b0;
          r_done      <= 1'b0;
          if (w_accept) begin
            r_state     <= SHIFT;
            r_ovl       <= bus.overlap;
            r_word      <= bus.in_data << 1;
            r_idx       <= c_IDX_W'(1);
            r_ser_valid <= 1'b1;
            r_ser_bit   <= w_bit;
            r_match     <= w_hit;
            r_cnt       <= w_cnt_next;
            // Non-overlapping mode restarts the window after every match.
            r_hist      <= (w_hit && !w_ovl) ? '0 : w_hist_next;
            r_fill      <= (w_hit && !w_ovl) ? '0 : w_fill_next;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_ser_valid <= 1'b0;
            r_ser_bit   <= 1'b0;
            r_match     <= 1'b0;
            r_cnt       <= '0;
          end else if (r_idx == c_IDX_LAST) begin
            r_state     <= REPORT;
            r_idx       <= '0;
            r_ser_valid <= 1'b0;
            r_ser_bit   <= 1'b0;
            r_match     <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_word      <= r_word << 1;
            r_idx       <= r_idx + 1'b1;
            r_ser_valid <= 1'b1;
            r_ser_bit   <= w_bit;
            r_match     <= w_hit;
            r_cnt       <= w_cnt_next;
            r_hist      <= (w_hit && !w_ovl) ? '0 : w_hist_next;
            r_fill      <= (w_hit && !w_ovl) ? '0 : w_fill_next;
          end
        end
        REPORT: begin
          // match_cnt is held here and through IDLE until the next accept.
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.ser_valid = r_ser_valid;
  assign bus.ser_bit   = r_ser_bit;
  assign bus.match     = r_match;
  assign bus.done      = r_done;
  assign bus.match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_detector_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_detector_scan_ctrl
// Purpose  : Self-checking bench for detector_scan_ctrl (DATA_W=16, PAT=1011)
//            using a queue-based reference matcher.
// Revision : 1.0  initial release
// ============================================================================
module tb_detector_scan_ctrl;

  localparam int             DW   = 16;
  localparam int             PW   = 4;
  localparam int             CW   = 5;
  localparam logic [PW-1:0]  PAT  = 4'b1011;
  localparam int             CMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  detector_scan_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  detector_scan_ctrl #(.DATA_W(DW), .PAT_W(PW), .PAT(PAT), .CNT_W(CW)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW+1:0] o_valid, o_bit, o_match, o_done, o_ready;
  logic [CW-1:0] o_cnt;
  logic          o_acc;
  logic [DW+1:0] e_mask, e_bits, full_valid, e_done;
  int            e_cnt;

  // Expected serial stream: position k (1..DW) carries w[DW-k].
  function automatic logic [DW+1:0] bits_of(input logic [DW-1:0] w);
    logic [DW+1:0] r;
    r = '0;
    for (int k = 1; k <= DW; k++) r[k] = w[DW-k];
    return r;
  endfunction

  // Reference matcher: a queue of bits received since the last history clear.
  function automatic void model(input logic [DW-1:0] w, input logic ovl,
                                output logic [DW+1:0] mask, output int cnt);
    bit q[$];
    bit ok;
    mask = '0;
    cnt  = 0;
    for (int k = 1; k <= DW; k++) begin
      q.push_back(w[DW-k]);
      if (q.size() >= PW) begin
        ok = 1'b1;
        for (int j = 0; j < PW; j++)
          if (q[q.size()-PW+j] != PAT[PW-1-j]) ok = 1'b0;
        if (ok) begin
          mask[k] = 1'b1;
          if (cnt < CMAX) cnt++;
          if (!ovl) q.delete();
        end
      end
    end
  endfunction

  // Drives one word and records every output for cycles 1..DW+1 after the
  // accept edge; optionally pulses abort or clr_n during cycle abort_at/rst_at.
  task automatic run_word(input logic [DW-1:0] w, input logic ovl,
                          input int abort_at, input int rst_at);
    int guard;
    guard = 0;
    o_valid = '0; o_bit = '0; o_match = '0; o_done = '0; o_ready = '0;
    o_cnt = '0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    o_acc = bus.in_ready;
    if (!o_acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", bus.in_ready, guard);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    bus.overlap  = ovl;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = DW'($urandom);
    bus.overlap  = 1'($urandom);
    for (int k = 1; k <= DW + 1; k++) begin
      o_valid[k] = bus.ser_valid;
      o_bit[k]   = bus.ser_bit;
      o_match[k] = bus.match;
      o_done[k]  = bus.done;
      o_ready[k] = bus.in_ready;
      if (k == abort_at) bus.abort = 1'b1;
      if (k == rst_at)   clr_n = 1'b0;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      clr_n     = 1'b1;
    end
    o_cnt = bus.match_cnt;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hB000;
    clr_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.ser_valid !== 1'b0) begin errors++; $display("FAIL reset_ser_valid: got %b want 0", bus.ser_valid); end
    checks++; if (bus.ser_bit !== 1'b0) begin errors++; $display("FAIL reset_ser_bit: got %b want 0", bus.ser_bit); end
    checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL reset_match: got %b want 0", bus.match); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.match_cnt !== '0) begin errors++; $display("FAIL reset_match_cnt: got %0d want 0", bus.match_cnt); end
    bus.in_valid = 1'b0;
    clr_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [DW-1:0] words [6] = '{16'hB000, 16'hB6C0, 16'hB6C0, 16'hAAAA, 16'h0000, 16'hFFFF};
    logic          ovls  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int            cnts  [6] = '{1, 3, 2, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      model(words[i], ovls[i], e_mask, e_cnt);
      e_bits = bits_of(words[i]);
      run_word(words[i], ovls[i], 0, 0);
      checks++; if (o_match !== e_mask) begin errors++; $display("FAIL dir%0d_match: got %h want %h", i, o_match, e_mask); end
      checks++; if ((o_bit & full_valid) !== e_bits) begin errors++; $display("FAIL dir%0d_bits: got %h want %h", i, o_bit & full_valid, e_bits); end
      checks++; if (o_valid !== full_valid) begin errors++; $display("FAIL dir%0d_valid: got %h want %h", i, o_valid, full_valid); end
      checks++; if (o_done !== e_done) begin errors++; $display("FAIL dir%0d_done: got %h want %h", i, o_done, e_done); end
      checks++; if (int'(o_cnt) !== cnts[i]) begin errors++; $display("FAIL dir%0d_cnt: got %0d want %0d", i, o_cnt, cnts[i]); end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    logic          ovl;
    for (int i = 0; i < 24; i++) begin
      for (int n = 0; n < DW / 4; n++)
        w[n*4 +: 4] = ($urandom_range(0, 1) == 1) ? PAT : 4'($urandom);
      ovl = 1'($urandom);
      model(w, ovl, e_mask, e_cnt);
      e_bits = bits_of(w);
      // Odd iterations also raise abort during REPORT, which must be ignored.
      run_word(w, ovl, (i % 2 == 1) ? DW + 1 : 0, 0);
      checks++; if (o_match !== e_mask) begin errors++; $display("FAIL rnd%0d_match: w=%h ovl=%b got %h want %h", i, w, ovl, o_match, e_mask); end
      checks++; if ((o_bit & full_valid) !== e_bits) begin errors++; $display("FAIL rnd%0d_bits: got %h want %h", i, o_bit & full_valid, e_bits); end
      checks++; if (o_done !== e_done) begin errors++; $display("FAIL rnd%0d_done: got %h want %h", i, o_done, e_done); end
      checks++; if (int'(o_cnt) !== e_cnt) begin errors++; $display("FAIL rnd%0d_cnt: w=%h ovl=%b got %0d want %0d", i, w, ovl, o_cnt, e_cnt); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w1, w2;
    logic [DW+1:0] b1;
    int            c;
    w1 = DW'($urandom);
    w2 = DW'($urandom);
    b1 = '0;
    c  = 1;
    bus.in_valid = 1'b1;
    bus.in_data  = w1;
    bus.overlap  = 1'b1;
    @(posedge clk); #1;
    bus.in_data = w2;
    while (!bus.in_ready && c < 40) begin
      if (c <= DW + 1) b1[c] = bus.ser_bit & bus.ser_valid;
      c++;
      @(posedge clk); #1;
    end
    checks++; if (c != DW + 2) begin errors++; $display("FAIL b2b_spacing: second accept at %0d want %0d", c, DW + 2); end
    checks++; if (b1 !== bits_of(w1)) begin errors++; $display("FAIL b2b_bits1: got %h want %h", b1, bits_of(w1)); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    b1 = '0;
    o_done = '0;
    for (int k = 1; k <= DW + 1; k++) begin
      b1[k]     = bus.ser_bit & bus.ser_valid;
      o_done[k] = bus.done;
      @(posedge clk); #1;
    end
    checks++; if (b1 !== bits_of(w2)) begin errors++; $display("FAIL b2b_bits2: got %h want %h", b1, bits_of(w2)); end
    checks++; if (o_done !== e_done) begin errors++; $display("FAIL b2b_done2: got %h want %h", o_done, e_done); end
  endtask

  task automatic test_abort();
    logic [DW+1:0] keep;
    keep = (DW+2)'(18'h0007E);
    model(16'hB6C0, 1'b1, e_mask, e_cnt);
    run_word(16'hB6C0, 1'b1, 6, 0);
    checks++; if (o_valid !== keep) begin errors++; $display("FAIL abort_valid: got %h want %h", o_valid, keep); end
    checks++; if (o_match !== (e_mask & keep)) begin errors++; $display("FAIL abort_match: got %h want %h", o_match, e_mask & keep); end
    checks++; if (o_ready[7] !== 1'b1) begin errors++; $display("FAIL abort_idle: in_ready=%b want 1", o_ready[7]); end
    checks++; if (o_done !== '0) begin errors++; $display("FAIL abort_done: got %h want 0", o_done); end
    checks++; if (o_cnt !== '0) begin errors++; $display("FAIL abort_cnt: got %0d want 0", o_cnt); end
    model(16'hB000, 1'b1, e_mask, e_cnt);
    run_word(16'hB000, 1'b1, 0, 0);
    checks++; if (o_match !== e_mask) begin errors++; $display("FAIL abort_next_match: got %h want %h", o_match, e_mask); end
    checks++; if (int'(o_cnt) !== e_cnt) begin errors++; $display("FAIL abort_next_cnt: got %0d want %0d", o_cnt, e_cnt); end
  endtask

  task automatic test_midreset();
    logic [DW+1:0] keep;
    keep = (DW+2)'(18'h003FE);
    model(16'hB6C0, 1'b1, e_mask, e_cnt);
    run_word(16'hB6C0, 1'b1, 0, 9);
    checks++; if (o_valid !== keep) begin errors++; $display("FAIL rst_valid: got %h want %h", o_valid, keep); end
    checks++; if (o_match !== (e_mask & keep)) begin errors++; $display("FAIL rst_match: got %h want %h", o_match, e_mask & keep); end
    checks++; if (o_ready[10] !== 1'b1) begin errors++; $display("FAIL rst_ready: in_ready=%b want 1", o_ready[10]); end
    checks++; if (o_done !== '0) begin errors++; $display("FAIL rst_done: got %h want 0", o_done); end
    checks++; if (o_cnt !== '0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", o_cnt); end
    model(16'hB6C0, 1'b0, e_mask, e_cnt);
    run_word(16'hB6C0, 1'b0, 0, 0);
    checks++; if (o_match !== e_mask) begin errors++; $display("FAIL rst_next_match: got %h want %h", o_match, e_mask); end
    checks++; if (int'(o_cnt) !== e_cnt) begin errors++; $display("FAIL rst_next_cnt: got %0d want %0d", o_cnt, e_cnt); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.overlap  = 1'b0;
    bus.abort    = 1'b0;
    full_valid   = bits_of({DW{1'b1}});
    e_done       = '0;
    e_done[DW+1] = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
